// File: rtl/tls_pkg.sv
// Traffic-light shared definitions:
// channel FSM states, timer modes, phase periods.
package tls_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  localparam int TL_WIDTH = 8;

  localparam logic [TL_WIDTH-1:0] T_MAIN_GREEN = 8'd30;
  localparam logic [TL_WIDTH-1:0] T_SIDE_GREEN = 8'd20;
  localparam logic [TL_WIDTH-1:0] T_YELLOW     = 8'd3;
  localparam logic [TL_WIDTH-1:0] T_ALL_RED    = 8'd2;
  localparam logic [TL_WIDTH-1:0] T_PED_WALK   = 8'd10;

  localparam int CH_MAIN = 0;
  localparam int CH_SIDE = 1;
  localparam int CH_PED  = 2;

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: IDLE/RUN FSM,
// tick decrement, one-shot or auto-reload.
module timer_channel
  import tls_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_sync,
  input  logic             enable_tick,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  input  logic             periodic,
  input  logic             cancel,
  output logic             expired,
  output logic             busy,
  output logic [WIDTH-1:0] remaining
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] reload;
  logic             mode;

  // Channel FSM; reset > cancel > start > tick.
  always_ff @(posedge clock) begin
    if (reset_sync) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      reload  <= '0;
      mode    <= MODE_ONESHOT;
      expired <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (cancel) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else if (start) begin
        if (value == '0) begin
          expired <= 1'b1;
          state   <= ST_IDLE;
          cnt     <= '0;
        end else begin
          cnt    <= value;
          reload <= value;
          mode   <= periodic;
          state  <= ST_RUN;
        end
      end else if (state == ST_RUN && enable_tick) begin
        if (cnt == ONE) begin
          expired <= 1'b1;
          if (mode == MODE_PERIODIC) begin
            cnt <= reload;
          end else begin
            cnt   <= '0;
            state <= ST_IDLE;
          end
        end else begin
          cnt <= cnt - ONE;
        end
      end
    end
  end

  assign busy      = (state == ST_RUN);
  assign remaining = cnt;

endmodule

// File: rtl/multi_timer.sv
// Bank of independent countdown channels
// sharing one tick strobe.
module multi_timer
  import tls_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 3
) (
  input  logic                      clock,
  input  logic                      reset_sync,
  input  logic                      enable_tick,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS*WIDTH-1:0] value,
  input  logic [CHANNELS-1:0]       periodic,
  input  logic [CHANNELS-1:0]       cancel,
  output logic [CHANNELS-1:0]       expired,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS*WIDTH-1:0] remaining
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    timer_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clock      (clock),
      .reset_sync (reset_sync),
      .enable_tick(enable_tick),
      .start      (start[i]),
      .value      (value[i*WIDTH +: WIDTH]),
      .periodic   (periodic[i]),
      .cancel     (cancel[i]),
      .expired    (expired[i]),
      .busy       (busy[i]),
      .remaining  (remaining[i*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_multi_timer.sv
// Directed self-checking bench for
// multi_timer (WIDTH=8, CHANNELS=3).
module tb_multi_timer;

  logic        clock;
  logic        reset_sync;
  logic        enable_tick;
  logic [2:0]  start;
  logic [23:0] value;
  logic [2:0]  periodic;
  logic [2:0]  cancel;
  logic [2:0]  expired;
  logic [2:0]  busy;
  logic [23:0] remaining;

  int compared;
  int mismatched;
  int seen;

  multi_timer #(.WIDTH(8), .CHANNELS(3)) dut (
    .clock      (clock),
    .reset_sync (reset_sync),
    .enable_tick(enable_tick),
    .start      (start),
    .value      (value),
    .periodic   (periodic),
    .cancel     (cancel),
    .expired    (expired),
    .busy       (busy),
    .remaining  (remaining)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    enable_tick = 1'b1;
    cyc();
    enable_tick = 1'b0;
  endtask

  task automatic go(input int ch, input logic [7:0] v,
                    input logic per);
    start[ch] = 1'b1;
    value[ch*8 +: 8] = v;
    periodic[ch] = per;
    cyc();
    start[ch] = 1'b0;
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    reset_sync  = 1'b1;
    enable_tick = 1'b0;
    start       = '0;
    value       = '0;
    periodic    = '0;
    cancel      = '0;
    #1;
    cyc();
    cyc();
    reset_sync = 1'b0;
    chk("rst_expired", 32'(expired), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_remaining", 32'(remaining), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_tick_expired", 32'(expired), 0);
    end

    // one-shot ch0, value 6
    go(0, 8'd6, 1'b0);
    chk("os_busy0", 32'(busy[0]), 1);
    chk("os_rem0", 32'(remaining[7:0]), 6);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("os_rem", 32'(remaining[7:0]), 32'(6 - k));
      chk("os_exp", 32'(expired[0]), (k == 6) ? 1 : 0);
      chk("os_busy", 32'(busy[0]), (k < 6) ? 1 : 0);
    end
    cyc();
    chk("os_exp_after", 32'(expired[0]), 0);

    // periodic ch1, value 2, 7 ticks
    go(1, 8'd2, 1'b1);
    chk("per_rem_start", 32'(remaining[15:8]), 2);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("per_exp", 32'(expired[1]), (k % 2 == 0) ? 1 : 0);
      chk("per_rem", 32'(remaining[15:8]), (k % 2 == 0) ? 2 : 1);
      chk("per_busy", 32'(busy[1]), 1);
    end
    cancel[1] = 1'b1;
    cyc();
    cancel[1] = 1'b0;
    chk("per_cancel_busy", 32'(busy[1]), 0);
    chk("per_cancel_rem", 32'(remaining[15:8]), 0);
    chk("per_cancel_exp", 32'(expired[1]), 0);

    // periodic reload 1: back-to-back pulses
    go(1, 8'd1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("b2b_exp", 32'(expired[1]), 1);
    end
    cancel[1] = 1'b1;
    cyc();
    cancel[1] = 1'b0;
    chk("b2b_cancel_exp", 32'(expired[1]), 0);

    // restart with coincident tick
    go(0, 8'd5, 1'b0);
    tick();
    tick();
    chk("col_rem3", 32'(remaining[7:0]), 3);
    enable_tick = 1'b1;
    go(0, 8'd3, 1'b0);
    enable_tick = 1'b0;
    chk("col_restart_rem", 32'(remaining[7:0]), 3);
    chk("col_restart_exp", 32'(expired[0]), 0);
    tick();
    tick();
    chk("col_rem1", 32'(remaining[7:0]), 1);
    chk("col_exp_early", 32'(expired[0]), 0);
    tick();
    chk("col_exp", 32'(expired[0]), 1);
    chk("col_busy", 32'(busy[0]), 0);

    // cancel beats start
    go(0, 8'd5, 1'b0);
    cancel[0] = 1'b1;
    go(0, 8'd4, 1'b0);
    cancel[0] = 1'b0;
    chk("cs_busy", 32'(busy[0]), 0);
    chk("cs_rem", 32'(remaining[7:0]), 0);
    chk("cs_exp", 32'(expired[0]), 0);
    cyc();
    chk("cs_exp2", 32'(expired[0]), 0);

    // value 0 on ch2
    go(2, 8'd0, 1'b1);
    chk("z_exp", 32'(expired[2]), 1);
    chk("z_busy", 32'(busy[2]), 0);
    chk("z_rem", 32'(remaining[23:16]), 0);
    cyc();
    chk("z_exp2", 32'(expired[2]), 0);

    // value 255, no wrap
    go(0, 8'd255, 1'b0);
    seen = 0;
    for (int k = 1; k <= 254; k++) begin
      tick();
      if (expired[0]) seen++;
    end
    chk("max_no_early", seen, 0);
    chk("max_rem1", 32'(remaining[7:0]), 1);
    tick();
    chk("max_exp", 32'(expired[0]), 1);
    chk("max_rem0", 32'(remaining[7:0]), 0);
    chk("max_busy", 32'(busy[0]), 0);

    // reset at remaining 1 with tick
    go(0, 8'd2, 1'b0);
    tick();
    chk("rr_rem1", 32'(remaining[7:0]), 1);
    reset_sync  = 1'b1;
    enable_tick = 1'b1;
    cyc();
    reset_sync  = 1'b0;
    enable_tick = 1'b0;
    chk("rr_exp", 32'(expired), 0);
    chk("rr_busy", 32'(busy), 0);
    chk("rr_rem", 32'(remaining), 0);
    cyc();
    chk("rr_exp2", 32'(expired), 0);

    // independence ch0 / ch2
    go(0, 8'd3, 1'b0);
    enable_tick = 1'b1;
    go(2, 8'd3, 1'b0);
    enable_tick = 1'b0;
    chk("ind_rem0", 32'(remaining[7:0]), 2);
    chk("ind_rem2", 32'(remaining[23:16]), 3);
    tick();
    chk("ind_rem0b", 32'(remaining[7:0]), 1);
    chk("ind_rem2b", 32'(remaining[23:16]), 2);
    cancel[2] = 1'b1;
    cyc();
    cancel[2] = 1'b0;
    chk("ind_busy2", 32'(busy[2]), 0);
    chk("ind_busy0", 32'(busy[0]), 1);
    tick();
    chk("ind_exp", 32'(expired), 32'b001);
    chk("ind_busy", 32'(busy), 0);
    chk("ind_rem1", 32'(remaining[15:8]), 0);
    cyc();
    chk("ind_exp2", 32'(expired), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
